// File: rtl/uart_op_sequencer_pkg.sv
// rtl/uart_op_sequencer_pkg.sv - shared types and constants for the UART operand sequencer
package uart_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    EXEC,
    SEND
  } seq_state_t;

endpackage

// File: rtl/uart_op_sequencer_if.sv
// rtl/uart_op_sequencer_if.sv - RX/TX byte streams between the UART core and the sequencer
interface uart_op_sequencer_if;
  import uart_seq_pkg::*;

  logic [BYTE_W-1:0] rx_byte;
  logic              rx_valid;
  logic [BYTE_W-1:0] tx_byte;
  logic              tx_valid;
  logic              tx_ready;

  // master is the UART core side, slave is the sequencer
  modport master (
    output rx_byte, rx_valid, tx_ready,
    input  tx_byte, tx_valid
  );

  modport slave (
    input  rx_byte, rx_valid, tx_ready,
    output tx_byte, tx_valid
  );

endinterface

// File: rtl/uart_op_sequencer_timeout_ctr.sv
// rtl/uart_op_sequencer_timeout_ctr.sv - saturating inter-byte timer with clear/enable/expire
module seq_timeout_ctr #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int              CW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear has priority so a byte arriving on the expiry cycle restarts the window
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/uart_op_sequencer.sv
// rtl/uart_op_sequencer.sv - frames UART bytes into an operand, runs the datapath, returns the result
// Optional trailing XOR checksum byte: UART_SEQ_CKSUM_EN
module uart_op_sequencer
  import uart_seq_pkg::*;
#(
  parameter int N_IN_BYTES  = 8,
  parameter int N_OUT_BYTES = 4,
  parameter int RES_LAT     = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  uart_op_sequencer_if.slave            uart,
  output logic [BYTE_W*N_IN_BYTES-1:0]  operand,
  output logic                          op_start,
  input  logic [BYTE_W*N_OUT_BYTES-1:0] result,
  output logic                          busy,
  output logic                          frame_err
);

  localparam int IN_W  = BYTE_W * N_IN_BYTES;
  localparam int OUT_W = BYTE_W * N_OUT_BYTES;
`ifdef UART_SEQ_CKSUM_EN
  localparam int N_TX  = N_OUT_BYTES + 1;
`else
  localparam int N_TX  = N_OUT_BYTES;
`endif
  localparam int MAX_B = (N_IN_BYTES > N_TX) ? N_IN_BYTES : N_TX;
  localparam int CNT_W = $clog2(MAX_B + 1);
  localparam int LAT_W = $clog2(RES_LAT + 1);

  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(N_IN_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_TX  = CNT_W'(N_TX - 1);
  localparam logic [LAT_W-1:0] LAT_DONE = LAT_W'(RES_LAT);

  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [IN_W-1:0]    operand_q, operand_d;
  logic               op_start_q, op_start_d;
  logic [OUT_W-1:0]   res_q, res_d;
  logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;
  logic               tx_valid_q, tx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               timer_expired;

  // Index N_OUT_BYTES selects the XOR of all result bytes when the checksum is built in
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [OUT_W-1:0] r,
                                                  input logic [CNT_W-1:0] idx);
    logic [BYTE_W-1:0] b;
    b = '0;
    for (int i = 0; i < N_OUT_BYTES; i++) begin
      if (idx == CNT_W'(i)) begin
        b = r[i*BYTE_W +: BYTE_W];
      end
    end
`ifdef UART_SEQ_CKSUM_EN
    if (idx == CNT_W'(N_OUT_BYTES)) begin
      for (int i = 0; i < N_OUT_BYTES; i++) begin
        b = b ^ r[i*BYTE_W +: BYTE_W];
      end
    end
`endif
    return b;
  endfunction

  seq_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (sys_clk),
    .rst     (rst),
    .clr     (uart.rx_valid || (state_q != RECV)),
    .en      (state_q == RECV),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    operand_d   = operand_q;
    op_start_d  = 1'b0;
    res_d       = res_q;
    tx_byte_d   = tx_byte_q;
    tx_valid_d  = tx_valid_q;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (uart.rx_valid) begin
          operand_d[BYTE_W-1:0] = uart.rx_byte;
          if (LAST_IN == '0) begin
            state_d    = EXEC;
            op_start_d = 1'b1;
            lat_d      = '0;
            cnt_d      = '0;
          end else begin
            state_d = RECV;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      RECV: begin
        if (uart.rx_valid) begin
          for (int i = 0; i < N_IN_BYTES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              operand_d[i*BYTE_W +: BYTE_W] = uart.rx_byte;
            end
          end
          if (cnt_q == LAST_IN) begin
            state_d    = EXEC;
            op_start_d = 1'b1;
            lat_d      = '0;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (timer_expired) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end

      // lat_q counts from 0 in the op_start cycle, so RES_LAT lands on result-valid
      EXEC: begin
        if (lat_q == LAT_DONE) begin
          res_d      = result;
          tx_byte_d  = pick_byte(result, '0);
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = SEND;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      SEND: begin
        if (tx_valid_q && uart.tx_ready) begin
          if (cnt_q == LAST_TX) begin
            tx_valid_d = 1'b0;
            tx_byte_d  = '0;
            cnt_d      = '0;
            state_d    = IDLE;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            tx_byte_d = pick_byte(res_q, cnt_q + 1'b1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_q       <= '0;
      operand_q   <= '0;
      op_start_q  <= 1'b0;
      res_q       <= '0;
      tx_byte_q   <= '0;
      tx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      operand_q   <= operand_d;
      op_start_q  <= op_start_d;
      res_q       <= res_d;
      tx_byte_q   <= tx_byte_d;
      tx_valid_q  <= tx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign operand       = operand_q;
  assign op_start      = op_start_q;
  assign uart.tx_byte  = tx_byte_q;
  assign uart.tx_valid = tx_valid_q;
  assign busy          = (state_q != IDLE);
  assign frame_err     = frame_err_q;

endmodule
